// File: rtl/fetch_unit.sv
// fetch_unit: Y86-64 pipeline fetch stage.
// Owns the F register (predicted PC) and the D pipeline register. Selects the
// fetch PC (memory-stage mispredict, then return, then prediction), decodes the
// instruction bytes, classifies status and freezes in HALTED after a non-AOK
// instruction enters D until a redirect arrives.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   F_stall                 hold the predicted PC
//   D_stall, D_bubble       hold / bubble the D register (bubble wins)
//   M_icode, M_Cnd, M_valA  memory-stage mispredicted-jump redirect
//   W_icode, W_valM         writeback-stage return redirect
//   imem_addr               fetch address (combinational, equals f_PC)
//   imem_data, imem_error   10 instruction bytes (byte k at [8k+7:8k]), fault
//   D_stat .. D_valP        D register contents
//   halted                  high while frozen after a non-AOK instruction
//   perf_fetched, perf_bubbles  D load counters (FETCH_PERF_EN only)
//
// Optional feature macro: FETCH_PERF_EN.
module fetch_unit #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       IMEM_SIZE = 4096,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic [3:0]        M_icode,
    input  logic              M_Cnd,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_valM,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [79:0]       imem_data,
    input  logic              imem_error,
    output logic [2:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [63:0]       D_valC,
    output logic [ADDR_W-1:0] D_valP,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles,
`endif
    output logic              halted
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd3;
    localparam logic [2:0] STAT_HLT = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    // Wide enough that f_PC + length never wraps in the bounds check.
    localparam int unsigned SUM_W = ((ADDR_W > 32) ? ADDR_W : 32) + 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] pred_pc;
    logic              redirect_m, redirect_w, redirect;
    logic [ADDR_W-1:0] f_pc;

    logic [3:0]        raw_icode, raw_ifun;
    logic              need_regids, need_valc;
    logic [3:0]        ins_len;
    logic [SUM_W-1:0]  end_addr;
    logic              addr_err, ins_err;
    logic [2:0]        f_stat;
    logic [3:0]        f_icode, f_ifun, f_ra, f_rb;
    logic [63:0]       f_valc;
    logic [ADDR_W-1:0] f_valp, f_predpc;

    logic              f_update, d_load_fields, d_load_bubble;

    // PC select: mispredicted jump beats return beats prediction.
    always_comb begin
        redirect_m = (M_icode == I_JXX) && !M_Cnd;
        redirect_w = (W_icode == I_RET);
        redirect   = redirect_m || redirect_w;
        if (redirect_m) begin
            f_pc = M_valA;
        end else if (redirect_w) begin
            f_pc = W_valM;
        end else begin
            f_pc = pred_pc;
        end
    end

    assign imem_addr = f_pc;

    // Instruction decode, length, status and next-PC prediction.
    always_comb begin
        raw_icode   = imem_data[7:4];
        raw_ifun    = imem_data[3:0];
        need_regids = raw_icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                        I_OPQ, I_PUSHQ, I_POPQ};
        need_valc   = raw_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};

        ins_len  = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
        f_valp   = f_pc + ADDR_W'(ins_len);
        end_addr = SUM_W'(f_pc) + SUM_W'(ins_len);
        addr_err = imem_error || (end_addr > SUM_W'(IMEM_SIZE));

        f_icode = raw_icode;
        f_ifun  = raw_ifun;
        f_ra    = need_regids ? imem_data[15:12] : R_NONE;
        f_rb    = need_regids ? imem_data[11:8]  : R_NONE;
        if (!need_valc) begin
            f_valc = 64'd0;
        end else if (need_regids) begin
            f_valc = imem_data[79:16];
        end else begin
            f_valc = imem_data[71:8];
        end

        // Prediction uses the raw fields; an address fault halts anyway.
        f_predpc = (raw_icode == I_JXX || raw_icode == I_CALL) ? ADDR_W'(f_valc) : f_valp;

        case (raw_icode)
            I_OPQ:                   ins_err = raw_ifun > 4'd3;
            I_RRMOVQ, I_JXX:         ins_err = raw_ifun > 4'd6;
            4'hC, 4'hD, 4'hE, 4'hF:  ins_err = 1'b1;
            default:                 ins_err = raw_ifun != 4'd0;
        endcase

        if (addr_err) begin
            f_stat  = STAT_ADR;
            f_icode = I_NOP;
            f_ifun  = 4'd0;
            f_ra    = R_NONE;
            f_rb    = R_NONE;
            f_valc  = 64'd0;
        end else if (ins_err) begin
            f_stat = STAT_INS;
        end else if (raw_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: a redirect makes HALTED behave as RUN for that cycle.
    always_comb begin
        next_state = state;
        if (state == ST_RUN || redirect) begin
            next_state = (d_load_fields && f_stat != STAT_AOK) ? ST_HALTED : ST_RUN;
        end
    end

    // FSM outputs: register enables and the halted flag.
    always_comb begin
        f_update      = 1'b0;
        d_load_fields = 1'b0;
        d_load_bubble = 1'b0;
        halted        = (state == ST_HALTED);
        if (state == ST_RUN || redirect) begin
            f_update      = !F_stall;
            d_load_bubble = D_bubble;
            d_load_fields = !D_bubble && !D_stall;
        end else begin
            d_load_bubble = D_bubble || !D_stall;
        end
    end

    // F register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc <= RESET_PC;
        end else if (f_update) begin
            pred_pc <= f_predpc;
        end
    end

    // D register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_stat  <= STAT_AOK;
            D_icode <= I_NOP;
            D_ifun  <= 4'd0;
            D_rA    <= R_NONE;
            D_rB    <= R_NONE;
            D_valC  <= 64'd0;
            D_valP  <= '0;
        end else if (d_load_bubble) begin
            D_stat  <= STAT_AOK;
            D_icode <= I_NOP;
            D_ifun  <= 4'd0;
            D_rA    <= R_NONE;
            D_rB    <= R_NONE;
            D_valC  <= 64'd0;
            D_valP  <= '0;
        end else if (d_load_fields) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_ra;
            D_rB    <= f_rb;
            D_valC  <= f_valc;
            D_valP  <= f_valp;
        end
    end

`ifdef FETCH_PERF_EN
    // D load counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_bubbles <= 32'd0;
        end else begin
            if (d_load_fields) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (d_load_bubble) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized bench for fetch_unit with a
// behavioural model of the fetch stage and an instruction memory.
module tb_fetch_unit;

    localparam int unsigned MEM = 4096;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    typedef struct packed {
        dreg_t       d;
        logic [63:0] pred;
    } fetch_t;

    typedef struct packed {
        logic [63:0] pred;
        logic        halt;
        dreg_t       d;
        logic [31:0] nf;
        logic [31:0] nb;
    } mstate_t;

    localparam dreg_t BUBBLE = '{stat: 3'd1, icode: 4'd1, ifun: 4'd0, ra: 4'd15,
                                 rb: 4'd15, valc: 64'd0, valp: 64'd0};

    logic        clk;
    logic        rst_n;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    logic [7:0]  mem [0:MEM-1];
    logic        err_inj;
    logic        cmp_en;
    int          n_cmp;
    int          n_fail;

    fetch_unit #(.ADDR_W(64), .IMEM_SIZE(MEM), .RESET_PC(64'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .imem_addr(imem_addr), .imem_data(imem_data), .imem_error(imem_error),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: wraps modulo MEM, faults at or above MEM.
    always_comb begin
        imem_data = '0;
        for (int k = 0; k < 10; k++) begin
            imem_data[8*k +: 8] = mem[12'(imem_addr[11:0] + 12'(k))];
        end
    end
    assign imem_error = (imem_addr >= 64'(MEM)) || err_inj;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fetch one instruction at pc as the instruction-set rules describe it.
    function automatic fetch_t model_fetch(input logic [63:0] pc, input logic err);
        logic [7:0]  b [10];
        fetch_t      r;
        int          nr, nv, len;
        logic        bad;
        logic [64:0] endp;
        for (int k = 0; k < 10; k++) b[k] = mem[12'(int'(pc[11:0]) + k)];
        r.d.icode = b[0][7:4];
        r.d.ifun  = b[0][3:0];
        nr  = (r.d.icode inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11}) ? 1 : 0;
        nv  = (r.d.icode inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8}) ? 1 : 0;
        len = 1 + nr + 8 * nv;
        r.d.ra   = (nr == 1) ? b[1][7:4] : 4'd15;
        r.d.rb   = (nr == 1) ? b[1][3:0] : 4'd15;
        r.d.valc = 64'd0;
        if (nv == 1) begin
            for (int k = 0; k < 8; k++) r.d.valc[8*k +: 8] = b[1 + nr + k];
        end
        r.d.valp = pc + 64'(len);
        r.pred   = (r.d.icode == 4'd7 || r.d.icode == 4'd8) ? r.d.valc : r.d.valp;
        endp     = {1'b0, pc} + 65'(len);
        if (r.d.icode > 4'd11)                          bad = 1'b1;
        else if (r.d.icode == 4'd6)                     bad = r.d.ifun > 4'd3;
        else if (r.d.icode == 4'd2 || r.d.icode == 4'd7) bad = r.d.ifun > 4'd6;
        else                                            bad = r.d.ifun != 4'd0;
        if (err || endp > 65'(MEM)) begin
            r.d.stat  = 3'd2;
            r.d.icode = 4'd1;
            r.d.ifun  = 4'd0;
            r.d.ra    = 4'd15;
            r.d.rb    = 4'd15;
            r.d.valc  = 64'd0;
        end else if (bad) begin
            r.d.stat = 3'd3;
        end else if (r.d.icode == 4'd0) begin
            r.d.stat = 3'd4;
        end else begin
            r.d.stat = 3'd1;
        end
        return r;
    endfunction

    // One clock of the stage: run (or redirected) vs frozen.
    function automatic mstate_t model_step(input mstate_t s, input logic redir,
                                           input logic [63:0] pc, input logic err,
                                           input logic fst, input logic dst, input logic dbub);
        mstate_t n;
        fetch_t  f;
        n = s;
        f = model_fetch(pc, err);
        if (!s.halt || redir) begin
            if (!fst) n.pred = f.pred;
            n.halt = 1'b0;
            if (dbub) begin
                n.d  = BUBBLE;
                n.nb = s.nb + 32'd1;
            end else if (!dst) begin
                n.d    = f.d;
                n.nf   = s.nf + 32'd1;
                n.halt = (f.d.stat != 3'd1);
            end
        end else if (dbub || !dst) begin
            n.d  = BUBBLE;
            n.nb = s.nb + 32'd1;
        end
        return n;
    endfunction

    mstate_t     m;
    logic        m_redir;
    logic [63:0] m_pc;
    logic        m_err;

    assign m_redir = (M_icode == 4'd7 && !M_Cnd) || (W_icode == 4'd9);
    assign m_pc    = (M_icode == 4'd7 && !M_Cnd) ? M_valA : (W_icode == 4'd9) ? W_valM : m.pred;
    assign m_err   = (m_pc >= 64'(MEM)) || err_inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{pred: 64'd0, halt: 1'b0, d: BUBBLE, nf: 32'd0, nb: 32'd0};
        end else begin
            m <= model_step(m, m_redir, m_pc, m_err, F_stall, D_stall, D_bubble);
        end
    end

    // Compare every cycle, mid-cycle, against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("D_stat", 64'(D_stat), 64'(m.d.stat));
            chk("D_icode", 64'(D_icode), 64'(m.d.icode));
            chk("D_ifun", 64'(D_ifun), 64'(m.d.ifun));
            chk("D_rA", 64'(D_rA), 64'(m.d.ra));
            chk("D_rB", 64'(D_rB), 64'(m.d.rb));
            chk("D_valC", D_valC, m.d.valc);
            chk("D_valP", D_valP, m.d.valp);
            chk("halted", 64'(halted), 64'(m.halt));
`ifdef FETCH_PERF_EN
            chk("perf_fetched", 64'(perf_fetched), 64'(m.nf));
            chk("perf_bubbles", 64'(perf_bubbles), 64'(m.nb));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        M_icode  = 4'd0;
        M_Cnd    = 1'b1;
        M_valA   = 64'd0;
        W_icode  = 4'd0;
        W_valM   = 64'd0;
        err_inj  = 1'b0;
    endtask

    task automatic jump_to(input logic [63:0] a);
        M_icode = 4'd7;
        M_Cnd   = 1'b0;
        M_valA  = a;
    endtask

    task automatic put(input int a, input logic [79:0] bytes, input int n);
        for (int k = 0; k < n; k++) mem[a + k] = bytes[8*k +: 8];
    endtask

    function automatic logic [63:0] rand_addr();
        int s;
        s = $urandom_range(0, 19);
        if (s < 16)      return 64'($urandom_range(0, MEM - 1));
        else if (s < 19) return 64'($urandom_range(MEM - 16, MEM + 100));
        else             return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
    endfunction

    logic [63:0] tbl_addr [5];
    logic [2:0]  tbl_stat [5];
    int          n;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cmp_en = 1'b0;
        idle();
        for (int i = 0; i < MEM; i++) mem[i] = 8'h10;
        put(0,      80'h00_0000_0000_0000_0A_F4_30, 10);  // irmovq $10,%rsp
        put('h20,   80'h00_0000_0000_0001_00_70,     9);  // jmp 0x100
        mem['h30] = 8'h00;                                // halt
        put('h40,   80'h23_60,                       2);  // addq %rdx,%rbx
        put('h200,  80'h12_63,                       2);
        put('h210,  80'h12_64,                       2);
        mem['h220] = 8'hC0;
        put('h230,  80'h45_21,                       2);
        mem['h240] = 8'h11;
        put(4086,   80'h00_0000_0000_0000_0A_F4_30, 10);

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        #2;
        chk("rst_stat", 64'(D_stat), 64'd1);
        chk("rst_icode", 64'(D_icode), 64'd1);
        chk("rst_rA", 64'(D_rA), 64'd15);
        chk("rst_rB", 64'(D_rB), 64'd15);
        chk("rst_valC", D_valC, 64'd0);
        chk("rst_valP", D_valP, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        tick();
        rst_n = 1'b1;

        // irmovq at reset PC
        tick();
        chk("irm_icode", 64'(D_icode), 64'd3);
        chk("irm_rB", 64'(D_rB), 64'd4);
        chk("irm_valC", D_valC, 64'd10);
        chk("irm_valP", D_valP, 64'd10);
        chk("irm_stat", 64'(D_stat), 64'd1);
        chk("irm_pred", imem_addr, 64'd10);

        // jmp prediction, then zero-cycle mispredict redirect
        jump_to(64'h20);
        #1 chk("redir_20", imem_addr, 64'h20);
        tick();
        idle();
        chk("jmp_icode", 64'(D_icode), 64'd7);
        chk("jmp_valC", D_valC, 64'h100);
        chk("jmp_valP", D_valP, 64'h29);
        #1 chk("jmp_pred", imem_addr, 64'h100);
        jump_to(64'h29);
        #1 chk("redir_29", imem_addr, 64'h29);
        tick();
        idle();

        // run through nops into halt at 0x30
        n = 0;
        while (!halted && n < 20) begin
            tick();
            n++;
        end
        chk("halt_reached", 64'(halted), 64'd1);
        chk("halt_stat", 64'(D_stat), 64'd4);
        chk("halt_icode", 64'(D_icode), 64'd0);
        chk("halt_pred", imem_addr, 64'h31);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("frz_icode", 64'(D_icode), 64'd1);
            chk("frz_pred", imem_addr, 64'h31);
            chk("frz_halted", 64'(halted), 64'd1);
        end
        W_icode = 4'd9;
        W_valM  = 64'h40;
        #1 chk("ret_addr", imem_addr, 64'h40);
        tick();
        idle();
        chk("ret_halted", 64'(halted), 64'd0);
        chk("ret_icode", 64'(D_icode), 64'd6);
        chk("ret_rA", 64'(D_rA), 64'd2);
        chk("ret_rB", 64'(D_rB), 64'd3);

        // function-code legality
        tbl_addr = '{64'h200, 64'h210, 64'h220, 64'h230, 64'h240};
        tbl_stat = '{3'd1, 3'd3, 3'd3, 3'd1, 3'd3};
        for (int i = 0; i < 5; i++) begin
            jump_to(tbl_addr[i]);
            tick();
            idle();
            chk("ifun_stat", 64'(D_stat), 64'(tbl_stat[i]));
        end

        // memory bound: exact fit, then one byte over
        jump_to(64'd4086);
        tick();
        idle();
        chk("fit_stat", 64'(D_stat), 64'd1);
        chk("fit_valP", D_valP, 64'd4096);
        put(4087, 80'h00_0000_0000_0000_0A_F4_30, 9);
        jump_to(64'd4087);
        tick();
        idle();
        chk("adr_stat", 64'(D_stat), 64'd2);
        chk("adr_icode", 64'(D_icode), 64'd1);
        chk("adr_valC", D_valC, 64'd0);
        #1 chk("adr_halted", 64'(halted), 64'd1);

        // stall / bubble interaction and reset mid-stall
        jump_to(64'h40);
        tick();
        idle();
        chk("pre_icode", 64'(D_icode), 64'd6);
        D_stall  = 1'b1;
        D_bubble = 1'b1;
        tick();
        idle();
        chk("bub_icode", 64'(D_icode), 64'd1);
        chk("bub_rA", 64'(D_rA), 64'd15);
        jump_to(64'h40);
        tick();
        idle();
        D_stall = 1'b1;
        F_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_icode", 64'(D_icode), 64'd6);
            chk("stall_rA", 64'(D_rA), 64'd2);
            chk("stall_valP", D_valP, 64'h42);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_icode", 64'(D_icode), 64'd1);
        chk("mrst_addr", imem_addr, 64'd0);
        chk("mrst_halted", 64'(halted), 64'd0);
        tick();
        rst_n = 1'b1;
        idle();

        // randomized traffic over a mostly-legal random program image
        for (int i = 0; i < MEM; i++) begin
            mem[i] = ($urandom_range(0, 9) < 7) ? {4'($urandom_range(0, 11)), 4'd0}
                                                 : 8'($urandom);
        end
        for (int c = 0; c < 3000; c++) begin
            tick();
            F_stall  = ($urandom_range(0, 9) == 0);
            D_stall  = ($urandom_range(0, 6) == 0);
            D_bubble = ($urandom_range(0, 9) == 0);
            M_icode  = ($urandom_range(0, 9) < 2) ? 4'd7 : 4'($urandom_range(0, 15));
            M_Cnd    = 1'($urandom_range(0, 1));
            M_valA   = rand_addr();
            W_icode  = ($urandom_range(0, 11) == 0) ? 4'd9 : 4'($urandom_range(0, 8));
            W_valM   = rand_addr();
            err_inj  = ($urandom_range(0, 29) == 0);
        end
        tick();
        idle();
        tick();
        tick();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
